// File: rtl/mc_controller.sv
// Multicycle RV32I main controller with embedded ALU decoder.
// Define MC_ILLEGAL_TRAP_EN to trap unknown opcodes in a sticky TRAP state.

`ifndef MC_ALU_DEFS
`define MC_ALU_DEFS
`define ALU_ADD  4'b0000
`define ALU_SUB  4'b0001
`define ALU_AND  4'b0010
`define ALU_OR   4'b0011
`define ALU_XOR  4'b0100
`define ALU_SLT  4'b0101
`define ALU_SLTU 4'b0110
`define ALU_SLL  4'b0111
`define ALU_SR   4'b1000
`endif

module aludec (
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] alu_op,
  output logic [3:0] alu_control
);

  // Map ALUOp plus funct fields onto an ALU operation code
  always_comb begin
    alu_control = `ALU_ADD;
    case (alu_op)
      2'b00: alu_control = `ALU_ADD;
      2'b01: alu_control = `ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  alu_control = (op5 & funct7b5) ? `ALU_SUB : `ALU_ADD;
          3'b001:  alu_control = `ALU_SLL;
          3'b010:  alu_control = `ALU_SLT;
          3'b011:  alu_control = `ALU_SLTU;
          3'b100:  alu_control = `ALU_XOR;
          3'b101:  alu_control = `ALU_SR;
          3'b110:  alu_control = `ALU_OR;
          default: alu_control = `ALU_AND;
        endcase
      end
    endcase
  end

endmodule

module mc_controller #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControl,
  output logic       bus_timeout,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD,
    S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_LUI, S_AUIPC, S_ALUWB, S_BRANCH,
    S_JAL, S_JALR, S_JALR2
`ifdef MC_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] TMAX =
    CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic       pcw, irw, rgw, mrd, mwr, adr;
  logic [1:0] rsrc, sa, sb, alu_op;
  logic       waiting, hit;

  // Next-state selection; memory states hold until mem_ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          7'b0000011,
          7'b0100011: state_d = S_MEMADR;
          7'b0110011: state_d = S_EXECR;
          7'b0010011: state_d = S_EXECI;
          7'b1100011: state_d = S_BRANCH;
          7'b1101111: state_d = S_JAL;
          7'b1100111: state_d = S_JALR;
          7'b0110111: state_d = S_LUI;
          7'b0010111: state_d = S_AUIPC;
`ifdef MC_ILLEGAL_TRAP_EN
          default:    state_d = S_TRAP;
`else
          default:    state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_MEMWB,
      S_ALUWB,
      S_BRANCH:   state_d = S_FETCH;
      S_EXECR,
      S_EXECI,
      S_LUI,
      S_AUIPC,
      S_JAL,
      S_JALR2:    state_d = S_ALUWB;
      S_JALR:     state_d = S_JALR2;
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // Datapath controls decoded from the current state
  always_comb begin
    pcw    = 1'b0;
    irw    = 1'b0;
    rgw    = 1'b0;
    mrd    = 1'b0;
    mwr    = 1'b0;
    adr    = 1'b0;
    rsrc   = 2'b00;
    sa     = 2'b00;
    sb     = 2'b00;
    alu_op = 2'b00;
    case (state_q)
      S_FETCH: begin
        mrd  = 1'b1;
        sb   = 2'b10;
        rsrc = 2'b10;
        irw  = mem_ready;
        pcw  = mem_ready;
      end
      S_DECODE: begin
        sa = 2'b01;
        sb = 2'b01;
      end
      S_MEMADR: begin
        sa = 2'b10;
        sb = 2'b01;
      end
      S_MEMREAD: begin
        adr = 1'b1;
        mrd = 1'b1;
      end
      S_MEMWB: begin
        rsrc = 2'b01;
        rgw  = 1'b1;
      end
      S_MEMWRITE: begin
        adr = 1'b1;
        mwr = 1'b1;
      end
      S_EXECR: begin
        sa     = 2'b10;
        alu_op = 2'b10;
      end
      S_EXECI: begin
        sa     = 2'b10;
        sb     = 2'b01;
        alu_op = 2'b10;
      end
      S_LUI: begin
        sa = 2'b11;
        sb = 2'b01;
      end
      S_AUIPC: begin
        sa = 2'b01;
        sb = 2'b01;
      end
      S_ALUWB: rgw = 1'b1;
      S_BRANCH: begin
        sa     = 2'b10;
        alu_op = 2'b01;
        pcw    = br_taken;
      end
      S_JAL, S_JALR2: begin
        pcw = 1'b1;
        sa  = 2'b01;
        sb  = 2'b10;
      end
      S_JALR: begin
        sa = 2'b10;
        sb = 2'b01;
      end
      default: ;
    endcase
  end

  // Memory wait counter; wraps after each timeout pulse
  always_comb begin
    waiting = (mrd | mwr) & ~mem_ready;
    hit     = 1'b0;
    cnt_d   = '0;
    if (MEM_TIMEOUT > 0) begin
      hit = waiting && (cnt_q == TMAX);
      if (waiting && (state_d == state_q) && !hit)
        cnt_d = cnt_q + 1'b1;
    end
  end

  // State, wait counter and sticky illegal flag
`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  // Sticky flag set on entry to TRAP
  always_comb illegal_d = illegal_q | (state_d == S_TRAP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  assign illegal = illegal_q;
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign illegal = 1'b0;
`endif

  aludec u_aludec (
    .op5        (op[5]),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .alu_op     (alu_op),
    .alu_control(ALUControl)
  );

  // Strobes are killed by reset without waiting for a clock edge
  assign PCWrite     = pcw & ~reset;
  assign IRWrite     = irw & ~reset;
  assign RegWrite    = rgw & ~reset;
  assign MemRead     = mrd & ~reset;
  assign MemWrite    = mwr & ~reset;
  assign bus_timeout = hit & ~reset;
  assign AdrSrc      = adr;
  assign ResultSrc   = rsrc;
  assign ALUSrcA     = sa;
  assign ALUSrcB     = sb;

endmodule

// File: tb/tb_mc_controller.sv
// Directed-vector bench for mc_controller.
// Expected output words are hand-derived per state.

module tb_mc_controller;

  localparam logic [3:0] ADD = 4'b0000;
  localparam logic [3:0] SUB = 4'b0001;
  localparam logic [3:0] SR  = 4'b1000;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       br_taken;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemRead, MemWrite;
  logic       IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [3:0] ALUControl;
  logic       bus_timeout, illegal;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mc_controller #(.MEM_TIMEOUT(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .br_taken   (br_taken),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .bus_timeout(bus_timeout),
    .illegal    (illegal)
  );

  wire [17:0] obs = {PCWrite, AdrSrc, MemRead, MemWrite,
                     IRWrite, RegWrite, ResultSrc, ALUSrcA,
                     ALUSrcB, ALUControl, bus_timeout, illegal};

  function automatic logic [17:0] ev(
    input logic pcw, input logic adr,
    input logic mr, input logic mw,
    input logic irw, input logic rw,
    input logic [1:0] rs, input logic [1:0] sa,
    input logic [1:0] sb, input logic [3:0] alu,
    input logic bt, input logic ill);
    return {pcw, adr, mr, mw, irw, rw, rs, sa, sb, alu, bt, ill};
  endfunction

  task automatic chk(input string tag, input logic [17:0] e);
    nvec++;
    assert (obs === e) else begin
      nerr++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, e);
    end
  endtask

  task automatic cyc(input string tag, input logic [17:0] e);
    #1;
    chk(tag, e);
    @(negedge clk);
  endtask

  logic [17:0] v_rst, v_fr, v_fw, v_dec, v_wb;

  initial begin
    v_rst = ev(0,0,0,0,0,0,2'b10,2'b00,2'b10,ADD,0,0);
    v_fr  = ev(1,0,1,0,1,0,2'b10,2'b00,2'b10,ADD,0,0);
    v_fw  = ev(0,0,1,0,0,0,2'b10,2'b00,2'b10,ADD,0,0);
    v_dec = ev(0,0,0,0,0,0,2'b00,2'b01,2'b01,ADD,0,0);
    v_wb  = ev(0,0,0,0,0,1,2'b00,2'b00,2'b00,ADD,0,0);

    reset = 1'b1; op = 7'b0110011; funct3 = 3'b000;
    funct7b5 = 1'b0; br_taken = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    cyc("reset", v_rst);
    reset = 1'b0;

    // add
    cyc("add_fetch", v_fr);
    cyc("add_decode", v_dec);
    cyc("add_execr", ev(0,0,0,0,0,0,2'b00,2'b10,2'b00,ADD,0,0));
    cyc("add_aluwb", v_wb);

    // sub
    funct7b5 = 1'b1;
    cyc("sub_fetch", v_fr);
    cyc("sub_decode", v_dec);
    cyc("sub_execr", ev(0,0,0,0,0,0,2'b00,2'b10,2'b00,SUB,0,0));
    cyc("sub_aluwb", v_wb);

    // srai
    op = 7'b0010011; funct3 = 3'b101;
    cyc("srai_fetch", v_fr);
    cyc("srai_decode", v_dec);
    cyc("srai_execi", ev(0,0,0,0,0,0,2'b00,2'b10,2'b01,SR,0,0));
    cyc("srai_aluwb", v_wb);

    // lw, one fetch wait then three read waits
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    mem_ready = 1'b0;
    cyc("lw_fetch_wait", v_fw);
    mem_ready = 1'b1;
    cyc("lw_fetch", v_fr);
    cyc("lw_decode", v_dec);
    cyc("lw_memadr", ev(0,0,0,0,0,0,2'b00,2'b10,2'b01,ADD,0,0));
    mem_ready = 1'b0;
    cyc("lw_rd_w0", ev(0,1,1,0,0,0,2'b00,2'b00,2'b00,ADD,0,0));
    cyc("lw_rd_w1_to", ev(0,1,1,0,0,0,2'b00,2'b00,2'b00,ADD,1,0));
    cyc("lw_rd_w2", ev(0,1,1,0,0,0,2'b00,2'b00,2'b00,ADD,0,0));
    mem_ready = 1'b1;
    cyc("lw_rd_done", ev(0,1,1,0,0,0,2'b00,2'b00,2'b00,ADD,0,0));
    cyc("lw_memwb", ev(0,0,0,0,0,1,2'b01,2'b00,2'b00,ADD,0,0));

    // beq not taken then taken
    op = 7'b1100011; funct3 = 3'b000;
    cyc("beq_nt_fetch", v_fr);
    cyc("beq_nt_decode", v_dec);
    cyc("beq_nt_branch", ev(0,0,0,0,0,0,2'b00,2'b10,2'b00,SUB,0,0));
    br_taken = 1'b1;
    cyc("beq_t_fetch", v_fr);
    cyc("beq_t_decode", v_dec);
    cyc("beq_t_branch", ev(1,0,0,0,0,0,2'b00,2'b10,2'b00,SUB,0,0));
    br_taken = 1'b0;

    // jal
    op = 7'b1101111;
    cyc("jal_fetch", v_fr);
    cyc("jal_decode", v_dec);
    cyc("jal_jal", ev(1,0,0,0,0,0,2'b00,2'b01,2'b10,ADD,0,0));
    cyc("jal_aluwb", v_wb);

    // illegal opcode
    op = 7'b0000000;
    cyc("ill_fetch", v_fr);
    cyc("ill_decode", v_dec);
`ifdef MC_ILLEGAL_TRAP_EN
    cyc("ill_trap0", ev(0,0,0,0,0,0,2'b00,2'b00,2'b00,ADD,0,1));
    cyc("ill_trap1", ev(0,0,0,0,0,0,2'b00,2'b00,2'b00,ADD,0,1));
    reset = 1'b1;
    cyc("ill_reset", v_rst);
    reset = 1'b0;
`else
    cyc("ill_nop_fetch", v_fr);
    cyc("ill_decode2", v_dec);
`endif

    // sw interrupted by reset mid-access
    op = 7'b0100011; funct3 = 3'b010;
    cyc("sw_fetch", v_fr);
    cyc("sw_decode", v_dec);
    cyc("sw_memadr", ev(0,0,0,0,0,0,2'b00,2'b10,2'b01,ADD,0,0));
    mem_ready = 1'b0;
    #1;
    chk("sw_memwrite", ev(0,1,0,1,0,0,2'b00,2'b00,2'b00,ADD,0,0));
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("sw_async_rst", v_rst);
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b1;
    cyc("post_rst_fetch", v_fr);
    cyc("post_rst_decode", v_dec);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
